// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared widths, NOP/bubble constants and register-match helper for the ARM core
package arm_pkg;

  localparam int EXE_CMD_W = 4;
  localparam int REG_IDX_W = 4;

  localparam logic [EXE_CMD_W-1:0] EXE_NOP = '0;

  typedef struct packed {
    logic wb_en;
    logic mem_r;
    logic mem_w;
    logic b;
    logic s;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '{wb_en: 1'b0, mem_r: 1'b0, mem_w: 1'b0, b: 1'b0, s: 1'b0};

  // R0 writes are dropped by the register file, so a dest of 0 never produces a dependency.
  function automatic logic src_match(
    input logic [REG_IDX_W-1:0] src,
    input logic                 src_active,
    input logic [REG_IDX_W-1:0] dest,
    input logic                 dest_en
  );
    return src_active && dest_en && (dest != '0) && (src == dest);
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - RAW hazard detection for ID vs EX/MEM; FORWARDING_EN limits stalls to load-use
module hazard_unit
  import arm_pkg::*;
(
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rn,
  input  logic [REG_IDX_W-1:0] id_rm,
  input  logic                 id_uses_rn,
  input  logic                 id_two_src,
  input  logic                 ex_valid,
  input  logic                 ex_wb_en,
  input  logic                 ex_mem_r,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 mem_wb_en,
  input  logic [REG_IDX_W-1:0] mem_rd,
  output logic                 hazard_stall
);

  logic dep;

`ifdef FORWARDING_EN
  logic ex_load;
  logic unused_fwd;

  // Only a load in EX cannot be forwarded in time; everything else is bypassed externally.
  assign ex_load    = ex_valid & ex_mem_r;
  assign dep        = src_match(id_rn, id_uses_rn, ex_rd, ex_load)
                    | src_match(id_rm, id_two_src, ex_rd, ex_load);
  assign unused_fwd = ^{ex_wb_en, mem_wb_en, mem_rd};
`else
  logic ex_wr;
  logic unused_full;

  assign ex_wr       = ex_valid & ex_wb_en;
  assign dep         = src_match(id_rn, id_uses_rn, ex_rd,  ex_wr)
                     | src_match(id_rm, id_two_src, ex_rd,  ex_wr)
                     | src_match(id_rn, id_uses_rn, mem_rd, mem_wb_en)
                     | src_match(id_rm, id_two_src, mem_rd, mem_wb_en);
  assign unused_full = ex_mem_r;
`endif

  assign hazard_stall = ~rst & id_valid & dep;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with bubble insertion and saturating stall counter (option: FORWARDING_EN)
module id_ex_stage
  import arm_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 freeze_in,
  input  logic                 flush,
  input  logic                 id_valid,
  input  logic [WORD_W-1:0]    id_pc,
  input  logic [WORD_W-1:0]    id_rn_val,
  input  logic [WORD_W-1:0]    id_rm_val,
  input  logic [REG_IDX_W-1:0] id_rn,
  input  logic [REG_IDX_W-1:0] id_rm,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 id_uses_rn,
  input  logic                 id_two_src,
  input  logic [EXE_CMD_W-1:0] id_exe_cmd,
  input  logic                 id_mem_r,
  input  logic                 id_mem_w,
  input  logic                 id_wb_en,
  input  logic                 id_b,
  input  logic                 id_s,
  input  logic                 id_imm,
  input  logic [11:0]          id_shift_op,
  input  logic [23:0]          id_simm24,
  input  logic                 id_c,
  input  logic                 mem_wb_en,
  input  logic [REG_IDX_W-1:0] mem_rd,
  output logic                 ex_valid,
  output logic [WORD_W-1:0]    ex_pc,
  output logic [WORD_W-1:0]    ex_rn_val,
  output logic [WORD_W-1:0]    ex_rm_val,
  output logic [REG_IDX_W-1:0] ex_rn,
  output logic [REG_IDX_W-1:0] ex_rm,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic                 ex_uses_rn,
  output logic                 ex_two_src,
  output logic [EXE_CMD_W-1:0] ex_exe_cmd,
  output logic                 ex_mem_r,
  output logic                 ex_mem_w,
  output logic                 ex_wb_en,
  output logic                 ex_b,
  output logic                 ex_s,
  output logic                 ex_imm,
  output logic [11:0]          ex_shift_op,
  output logic [23:0]          ex_simm24,
  output logic                 ex_c,
  output logic [REG_IDX_W-1:0] ex_src1,
  output logic [REG_IDX_W-1:0] ex_src2,
  output logic                 hazard_stall,
  output logic [CNT_W-1:0]     stall_count
);

  logic                 bubble;
  ctrl_t                nxt_ctrl;
  logic                 nxt_valid;
  logic [WORD_W-1:0]    nxt_pc;
  logic [WORD_W-1:0]    nxt_rn_val;
  logic [WORD_W-1:0]    nxt_rm_val;
  logic [REG_IDX_W-1:0] nxt_rn;
  logic [REG_IDX_W-1:0] nxt_rm;
  logic [REG_IDX_W-1:0] nxt_rd;
  logic                 nxt_uses_rn;
  logic                 nxt_two_src;
  logic [EXE_CMD_W-1:0] nxt_exe_cmd;
  logic                 nxt_imm;
  logic [11:0]          nxt_shift_op;
  logic [23:0]          nxt_simm24;
  logic                 nxt_c;
  logic [REG_IDX_W-1:0] nxt_src1;
  logic [REG_IDX_W-1:0] nxt_src2;

  hazard_unit u_hazard (
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rn        (id_rn),
    .id_rm        (id_rm),
    .id_uses_rn   (id_uses_rn),
    .id_two_src   (id_two_src),
    .ex_valid     (ex_valid),
    .ex_wb_en     (ex_wb_en),
    .ex_mem_r     (ex_mem_r),
    .ex_rd        (ex_rd),
    .mem_wb_en    (mem_wb_en),
    .mem_rd       (mem_rd),
    .hazard_stall (hazard_stall)
  );

  assign bubble = flush | hazard_stall;

  // A bubble loads zeros everywhere so EX sees a clean NOP rather than stale data.
  always_comb begin
    nxt_valid    = 1'b0;
    nxt_ctrl     = BUBBLE_CTRL;
    nxt_pc       = '0;
    nxt_rn_val   = '0;
    nxt_rm_val   = '0;
    nxt_rn       = '0;
    nxt_rm       = '0;
    nxt_rd       = '0;
    nxt_uses_rn  = 1'b0;
    nxt_two_src  = 1'b0;
    nxt_exe_cmd  = EXE_NOP;
    nxt_imm      = 1'b0;
    nxt_shift_op = '0;
    nxt_simm24   = '0;
    nxt_c        = 1'b0;
    nxt_src1     = '0;
    nxt_src2     = '0;
    if (!bubble) begin
      nxt_valid    = id_valid;
      nxt_ctrl     = '{wb_en: id_wb_en, mem_r: id_mem_r, mem_w: id_mem_w, b: id_b, s: id_s};
      nxt_pc       = id_pc;
      nxt_rn_val   = id_rn_val;
      nxt_rm_val   = id_rm_val;
      nxt_rn       = id_rn;
      nxt_rm       = id_rm;
      nxt_rd       = id_rd;
      nxt_uses_rn  = id_uses_rn;
      nxt_two_src  = id_two_src;
      nxt_exe_cmd  = id_exe_cmd;
      nxt_imm      = id_imm;
      nxt_shift_op = id_shift_op;
      nxt_simm24   = id_simm24;
      nxt_c        = id_c;
      // Inactive sources are presented as R0 so the forwarding unit never matches them.
      nxt_src1     = id_uses_rn ? id_rn : '0;
      nxt_src2     = id_two_src ? id_rm : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_wb_en    <= 1'b0;
      ex_mem_r    <= 1'b0;
      ex_mem_w    <= 1'b0;
      ex_b        <= 1'b0;
      ex_s        <= 1'b0;
      ex_pc       <= '0;
      ex_rn_val   <= '0;
      ex_rm_val   <= '0;
      ex_rn       <= '0;
      ex_rm       <= '0;
      ex_rd       <= '0;
      ex_uses_rn  <= 1'b0;
      ex_two_src  <= 1'b0;
      ex_exe_cmd  <= '0;
      ex_imm      <= 1'b0;
      ex_shift_op <= '0;
      ex_simm24   <= '0;
      ex_c        <= 1'b0;
      ex_src1     <= '0;
      ex_src2     <= '0;
    end else if (!freeze_in) begin
      ex_valid    <= nxt_valid;
      ex_wb_en    <= nxt_ctrl.wb_en;
      ex_mem_r    <= nxt_ctrl.mem_r;
      ex_mem_w    <= nxt_ctrl.mem_w;
      ex_b        <= nxt_ctrl.b;
      ex_s        <= nxt_ctrl.s;
      ex_pc       <= nxt_pc;
      ex_rn_val   <= nxt_rn_val;
      ex_rm_val   <= nxt_rm_val;
      ex_rn       <= nxt_rn;
      ex_rm       <= nxt_rm;
      ex_rd       <= nxt_rd;
      ex_uses_rn  <= nxt_uses_rn;
      ex_two_src  <= nxt_two_src;
      ex_exe_cmd  <= nxt_exe_cmd;
      ex_imm      <= nxt_imm;
      ex_shift_op <= nxt_shift_op;
      ex_simm24   <= nxt_simm24;
      ex_c        <= nxt_c;
      ex_src1     <= nxt_src1;
      ex_src2     <= nxt_src2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (!freeze_in && hazard_stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage (both FORWARDING_EN builds)
module tb_id_ex_stage;
  import arm_pkg::*;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 16;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                 clk;
  logic                 rst;
  logic                 freeze_in;
  logic                 flush;
  logic                 id_valid;
  logic [WORD_W-1:0]    id_pc;
  logic [WORD_W-1:0]    id_rn_val;
  logic [WORD_W-1:0]    id_rm_val;
  logic [3:0]           id_rn;
  logic [3:0]           id_rm;
  logic [3:0]           id_rd;
  logic                 id_uses_rn;
  logic                 id_two_src;
  logic [3:0]           id_exe_cmd;
  logic                 id_mem_r;
  logic                 id_mem_w;
  logic                 id_wb_en;
  logic                 id_b;
  logic                 id_s;
  logic                 id_imm;
  logic [11:0]          id_shift_op;
  logic [23:0]          id_simm24;
  logic                 id_c;
  logic                 mem_wb_en;
  logic [3:0]           mem_rd;
  logic                 ex_valid;
  logic [WORD_W-1:0]    ex_pc;
  logic [WORD_W-1:0]    ex_rn_val;
  logic [WORD_W-1:0]    ex_rm_val;
  logic [3:0]           ex_rn;
  logic [3:0]           ex_rm;
  logic [3:0]           ex_rd;
  logic                 ex_uses_rn;
  logic                 ex_two_src;
  logic [3:0]           ex_exe_cmd;
  logic                 ex_mem_r;
  logic                 ex_mem_w;
  logic                 ex_wb_en;
  logic                 ex_b;
  logic                 ex_s;
  logic                 ex_imm;
  logic [11:0]          ex_shift_op;
  logic [23:0]          ex_simm24;
  logic                 ex_c;
  logic [3:0]           ex_src1;
  logic [3:0]           ex_src2;
  logic                 hazard_stall;
  logic [CNT_W-1:0]     stall_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  id_ex_stage #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .freeze_in(freeze_in), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rn_val(id_rn_val), .id_rm_val(id_rm_val),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd), .id_uses_rn(id_uses_rn),
    .id_two_src(id_two_src), .id_exe_cmd(id_exe_cmd), .id_mem_r(id_mem_r),
    .id_mem_w(id_mem_w), .id_wb_en(id_wb_en), .id_b(id_b), .id_s(id_s), .id_imm(id_imm),
    .id_shift_op(id_shift_op), .id_simm24(id_simm24), .id_c(id_c),
    .mem_wb_en(mem_wb_en), .mem_rd(mem_rd),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rn_val(ex_rn_val), .ex_rm_val(ex_rm_val),
    .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd), .ex_uses_rn(ex_uses_rn),
    .ex_two_src(ex_two_src), .ex_exe_cmd(ex_exe_cmd), .ex_mem_r(ex_mem_r),
    .ex_mem_w(ex_mem_w), .ex_wb_en(ex_wb_en), .ex_b(ex_b), .ex_s(ex_s), .ex_imm(ex_imm),
    .ex_shift_op(ex_shift_op), .ex_simm24(ex_simm24), .ex_c(ex_c),
    .ex_src1(ex_src1), .ex_src2(ex_src2),
    .hazard_stall(hazard_stall), .stall_count(stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Data operands are derived from the PC so each instruction carries distinct values.
  task automatic drive_id(input logic v, input logic [31:0] pc, input logic [3:0] rn,
                          input logic [3:0] rm, input logic [3:0] rd, input logic urn,
                          input logic two, input logic [3:0] cmd, input logic mr,
                          input logic mw, input logic wb);
    id_valid    = v;
    id_pc       = pc;
    id_rn_val   = pc + 32'h1000;
    id_rm_val   = pc + 32'h2000;
    id_rn       = rn;
    id_rm       = rm;
    id_rd       = rd;
    id_uses_rn  = urn;
    id_two_src  = two;
    id_exe_cmd  = cmd;
    id_mem_r    = mr;
    id_mem_w    = mw;
    id_wb_en    = wb;
    id_b        = 1'b0;
    id_s        = 1'b0;
    id_imm      = pc[2];
    id_shift_op = pc[11:0];
    id_simm24   = pc[23:0];
    id_c        = pc[3];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    freeze_in = 1'b0;
    flush     = 1'b0;
    mem_wb_en = 1'b1;
    mem_rd    = 4'd3;
    drive_id(1'b1, 32'h100, 4'd3, 4'd0, 4'd3, 1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b1);
    id_s = 1'b1;
    #1 check("rst_hazard_forced_low", hazard_stall, 0);
    tick();
    tick();
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ex_pc", ex_pc, 0);
    check("rst_ex_rd", ex_rd, 0);
    check("rst_ex_wb_en", ex_wb_en, 0);
    check("rst_ex_s", ex_s, 0);
    check("rst_stall_count", stall_count, 0);
    rst = 1'b0;
    mem_wb_en = 1'b0;
    mem_rd = 4'd0;

    // ADD R3 into EX
    drive_id(1'b1, 32'h104, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 4'h4, 1'b0, 1'b0, 1'b1);
    tick();
    check("add_ex_valid", ex_valid, 1);
    check("add_ex_rd", ex_rd, 3);
    check("add_ex_pc", ex_pc, 32'h104);
    check("add_ex_cmd", ex_exe_cmd, 4'h4);

`ifndef FORWARDING_EN
    // SUB reads R3 while ADD is in EX, then while it is in MEM
    drive_id(1'b1, 32'h108, 4'd3, 4'd0, 4'd4, 1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b1);
    #1 check("sub_ex_hazard", hazard_stall, 1);
    tick();
    exp_cnt = 1;
    check("sub_bubble1_valid", ex_valid, 0);
    check("sub_bubble1_wb_en", ex_wb_en, 0);
    check("sub_bubble1_count", stall_count, exp_cnt);
    mem_wb_en = 1'b1;
    mem_rd = 4'd3;
    #1 check("sub_mem_hazard", hazard_stall, 1);
    tick();
    exp_cnt = 2;
    check("sub_bubble2_valid", ex_valid, 0);
    check("sub_bubble2_count", stall_count, exp_cnt);
    mem_wb_en = 1'b0;
    mem_rd = 4'd0;
    #1 check("sub_no_hazard", hazard_stall, 0);
    tick();
    check("sub_load_valid", ex_valid, 1);
    check("sub_load_pc", ex_pc, 32'h108);
    check("sub_load_rd", ex_rd, 4);
    check("sub_load_rn_val", ex_rn_val, 32'h1108);
    check("sub_load_src1", ex_src1, 3);
    check("sub_load_src2", ex_src2, 0);
    check("sub_load_count", stall_count, exp_cnt);
`endif

    // LDR R5 into EX, then STR reading Rm=R5
    drive_id(1'b1, 32'h10C, 4'd0, 4'd0, 4'd5, 1'b0, 1'b0, 4'h4, 1'b1, 1'b0, 1'b1);
    tick();
    check("ldr_ex_mem_r", ex_mem_r, 1);
    check("ldr_ex_rd", ex_rd, 5);
    drive_id(1'b1, 32'h110, 4'd1, 4'd5, 4'd6, 1'b1, 1'b1, 4'h4, 1'b0, 1'b1, 1'b0);
    #1 check("ldr_use_hazard", hazard_stall, 1);
    tick();
    exp_cnt++;
    check("ldr_bubble_valid", ex_valid, 0);
    check("ldr_bubble_mem_w", ex_mem_w, 0);
    check("ldr_bubble_count", stall_count, exp_cnt);
    check("ldr_after_bubble_hazard", hazard_stall, 0);
    tick();
    check("str_load_valid", ex_valid, 1);
    check("str_load_mem_w", ex_mem_w, 1);
    check("str_load_src1", ex_src1, 1);
    check("str_load_src2", ex_src2, 5);
    check("str_load_rm_val", ex_rm_val, 32'h2110);
    check("str_load_two_src", ex_two_src, 1);
    check("str_load_count", stall_count, exp_cnt);

    // ADD R5 in EX: only the full-stall build stalls on an ALU result
    drive_id(1'b1, 32'h114, 4'd0, 4'd0, 4'd5, 1'b0, 1'b0, 4'h4, 1'b0, 1'b0, 1'b1);
    tick();
    drive_id(1'b1, 32'h118, 4'd5, 4'd0, 4'd7, 1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b1);
    #1 check("alu_result_hazard", hazard_stall, FWD ? 0 : 1);
    id_valid = 1'b0;
    #1 check("invalid_id_no_hazard", hazard_stall, 0);

    // EX writes R0, ID reads R0
    drive_id(1'b1, 32'h200, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'h4, 1'b0, 1'b0, 1'b1);
    tick();
    check("r0_ex_rd", ex_rd, 0);
    check("r0_ex_wb_en", ex_wb_en, 1);
    mem_wb_en = 1'b1;
    mem_rd = 4'd0;
    drive_id(1'b1, 32'h204, 4'd0, 4'd0, 4'd8, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b1);
    #1 check("r0_no_hazard", hazard_stall, 0);

    // Freeze with flush pending and a live MEM hazard
    mem_rd = 4'd7;
    freeze_in = 1'b1;
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_id(1'b1, 32'h300 + 32'(4 * i), 4'd7, 4'd0, 4'd9, 1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b1);
      tick();
      check("freeze_ex_pc", ex_pc, 32'h200);
      check("freeze_ex_valid", ex_valid, 1);
      check("freeze_count", stall_count, exp_cnt);
    end
    freeze_in = 1'b0;
    mem_wb_en = 1'b0;
    tick();
    check("flush_bubble_valid", ex_valid, 0);
    check("flush_bubble_pc", ex_pc, 0);
    check("flush_bubble_wb_en", ex_wb_en, 0);
    check("flush_bubble_count", stall_count, exp_cnt);
    flush = 1'b0;
    tick();
    check("post_flush_valid", ex_valid, 1);
    check("post_flush_pc", ex_pc, 32'h308);
    check("post_flush_rd", ex_rd, 9);

`ifndef FORWARDING_EN
    // Saturation of the stall counter
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("sat_reset_count", stall_count, 0);
    mem_wb_en = 1'b1;
    mem_rd = 4'd3;
    drive_id(1'b1, 32'h400, 4'd3, 4'd0, 4'd1, 1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b1);
    repeat (65534) @(posedge clk);
    #1 check("sat_count_fffe", stall_count, 16'hFFFE);
    tick();
    check("sat_count_ffff", stall_count, 16'hFFFF);
    tick();
    check("sat_count_hold", stall_count, 16'hFFFF);
    check("sat_hazard_still", hazard_stall, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
